divider_8bit: RTL and testbench

- Sequential signed 8-bit divider: the inverse companion of the lab's shift-add multiplier.
- Uses the same board-level interface: switches S, buttons ClearA_LoadB and Run, register views Aval/Bval, four 7-segment outputs.
- Dividend is loaded into B. Divisor is taken from S at start.
- Result: quotient in B, remainder in A.
- Uses a restoring shift-subtract algorithm on magnitudes, then sign fix-up.

---
 rtl/divider_8bit_pkg.sv | 17 +
 rtl/divider_8bit_hex_driver.sv | 11 +
 rtl/divider_8bit.sv | 128 ++++++++++++
 tb/tb_divider_8bit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_8bit_pkg.sv
// Shared definitions for the divider lab: operand width, control states and
// the active-low 7-segment lookup that the multiplier lab also uses.
package divider_8bit_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;

  // Hex digits 0-F, segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/divider_8bit_hex_driver.sv
// One 7-segment digit: a nibble in, an active-low segment pattern out.
import divider_8bit_pkg::*;

module hex_driver (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/divider_8bit.sv
// Sequential signed divider: restoring shift-subtract on magnitudes with a
// sign fix-up at the end. Quotient lands in B, remainder in A.
import divider_8bit_pkg::*;

module divider_8bit (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             DivZero,
  output logic             Ovf,
  output logic [6:0]       AhexL,
  output logic [6:0]       AhexU,
  output logic [6:0]       BhexL,
  output logic [6:0]       BhexU
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LASTCNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] a, b, d, quo;
  logic [WIDTH:0]   rem, dmag;
  logic [CW-1:0]    cnt;
  logic             signq, signr, divzero, ovf;

  logic [WIDTH:0]   bext, dext, babs, dabs, trial;

  // Nine-bit magnitudes so that |-2^(WIDTH-1)| is representable
  always_comb begin
    bext  = {b[WIDTH-1], b};
    dext  = {d[WIDTH-1], d};
    babs  = bext[WIDTH] ? -bext : bext;
    dabs  = dext[WIDTH] ? -dext : dext;
    trial = {rem[WIDTH-1:0], quo[WIDTH-1]};
  end

  // Control and datapath share one block; A/B only change on load,
  // on the SETUP special cases and in FIX, never mid-iteration
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      d       <= '0;
      quo     <= '0;
      rem     <= '0;
      dmag    <= '0;
      cnt     <= '0;
      signq   <= 1'b0;
      signr   <= 1'b0;
      divzero <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ClearA_LoadB) begin
            a <= '0;
            b <= S;
          end else if (!Run) begin
            d     <= S;
            state <= SETUP;
          end
        end
        SETUP: begin
          signq <= b[WIDTH-1] ^ d[WIDTH-1];
          signr <= b[WIDTH-1];
          dmag  <= dabs;
          quo   <= babs[WIDTH-1:0];
          rem   <= '0;
          cnt   <= '0;
          if (d == '0) begin
            divzero <= 1'b1;
            ovf     <= 1'b0;
            b       <= '1;
            a       <= b;
            state   <= DONE;
          end else if (b == MOSTNEG && d == '1) begin
            divzero <= 1'b0;
            ovf     <= 1'b1;
            b       <= MOSTNEG;
            a       <= '0;
            state   <= DONE;
          end else begin
            divzero <= 1'b0;
            ovf     <= 1'b0;
            state   <= ITER;
          end
        end
        ITER: begin
          if (trial >= dmag) begin
            rem <= trial - dmag;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= trial;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LASTCNT) state <= FIX;
        end
        FIX: begin
          b     <= signq ? -quo : quo;
          a     <= signr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          state <= DONE;
        end
        DONE: begin
          if (Run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval    = a;
  assign Bval    = b;
  assign DivZero = divzero;
  assign Ovf     = ovf;

  hex_driver u_hex_al (.nibble(a[3:0]), .seg(AhexL));
  hex_driver u_hex_au (.nibble(a[7:4]), .seg(AhexU));
  hex_driver u_hex_bl (.nibble(b[3:0]), .seg(BhexL));
  hex_driver u_hex_bu (.nibble(b[7:4]), .seg(BhexU));

endmodule

// File: tb/tb_divider_8bit.sv
// Self-checking bench for divider_8bit: a transaction-level reference model
// compared every cycle, plus directed literal expectations and random runs.
module tb_divider_8bit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ClearA_LoadB = 1'b1;
  logic       Run = 1'b1;
  logic [7:0] S = 8'h00;
  logic [7:0] Aval, Bval;
  logic       DivZero, Ovf;
  logic [6:0] AhexL, AhexU, BhexL, BhexU;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  divider_8bit dut (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .S(S),
    .Aval(Aval), .Bval(Bval), .DivZero(DivZero), .Ovf(Ovf),
    .AhexL(AhexL), .AhexU(AhexU), .BhexL(BhexL), .BhexU(BhexU)
  );

  // Reference model state: what A/B/flags must show, and run progress
  logic [7:0] expA = 8'h00, expB = 8'h00;
  logic       expDz = 1'b0, expOv = 1'b0;
  logic [7:0] pendQ, pendR;
  logic       pendDz, pendOv;
  int         phase = 0;
  int         elapsed = 0;

  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic refDiv(input logic [7:0] dvd, input logic [7:0] dvs,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output logic ov);
    int x, y;
    x = int'($signed(dvd));
    y = int'($signed(dvs));
    dz = 1'b0;
    ov = 1'b0;
    if (y == 0) begin
      q = 8'hFF; r = dvd; dz = 1'b1;
    end else if (x == -128 && y == -1) begin
      q = 8'h80; r = 8'h00; ov = 1'b1;
    end else begin
      q = 8'(x / y);
      r = 8'(x % y);
    end
  endtask

  // Flags settle one clock after the start sample; normal results after ten
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      expA = 8'h00; expB = 8'h00; expDz = 1'b0; expOv = 1'b0; phase = 0;
    end else begin
      case (phase)
        0: begin
          if (!ClearA_LoadB) begin
            expA = 8'h00; expB = S;
          end else if (!Run) begin
            refDiv(expB, S, pendQ, pendR, pendDz, pendOv);
            elapsed = 0;
            phase = 1;
          end
        end
        1: begin
          elapsed++;
          if (elapsed == 1) begin
            expDz = pendDz;
            expOv = pendOv;
            if (pendDz || pendOv) begin
              expA = pendR; expB = pendQ; phase = 2;
            end
          end else if (elapsed == 10) begin
            expA = pendR; expB = pendQ; phase = 2;
          end
        end
        default: if (Run) phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    checkOutput("model_A", 32'(Aval), 32'(expA));
    checkOutput("model_B", 32'(Bval), 32'(expB));
    checkOutput("model_flags", 32'({DivZero, Ovf}), 32'({expDz, expOv}));
    checkOutput("model_hex", 32'({AhexU, AhexL, BhexU, BhexL}),
                32'({segOf(expA[7:4]), segOf(expA[3:0]), segOf(expB[7:4]), segOf(expB[3:0])}));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic loadB(input logic [7:0] val);
    ClearA_LoadB = 1'b0;
    S = val;
    tick(1);
    ClearA_LoadB = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] divisor, input int hold);
    S = divisor;
    Run = 1'b0;
    tick(hold);
    Run = 1'b1;
    tick(2);
  endtask

  task automatic checkResult(input string name, input logic [7:0] q, input logic [7:0] r,
                             input logic dz, input logic ov);
    checkOutput({name, "_B"}, 32'(Bval), 32'(q));
    checkOutput({name, "_A"}, 32'(Aval), 32'(r));
    checkOutput({name, "_flags"}, 32'({DivZero, Ovf}), 32'({dz, ov}));
  endtask

  function automatic logic [7:0] randOperand();
    logic [7:0] edges [5];
    edges = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  initial begin
    tick(2);
    Reset = 1'b0;
    tick(1);
    checkResult("reset", 8'h00, 8'h00, 1'b0, 1'b0);

    // -59 / 7, with exact-latency probes
    loadB(8'hC5);
    S = 8'h07;
    Run = 1'b0;
    tick(1);
    tick(5);
    checkResult("t1_mid", 8'hC5, 8'h00, 1'b0, 1'b0);
    tick(4);
    checkResult("t1_early", 8'hC5, 8'h00, 1'b0, 1'b0);
    tick(1);
    checkResult("t1_at10", 8'hF8, 8'hFD, 1'b0, 1'b0);
    tick(40);
    checkResult("t1_held", 8'hF8, 8'hFD, 1'b0, 1'b0);
    checkOutput("t1_bhexu", 32'(BhexU), 32'(7'b0001110));
    checkOutput("t1_bhexl", 32'(BhexL), 32'(7'b0000000));
    Run = 1'b1;
    tick(2);

    loadB(8'h64);
    applyStimulus(8'h07, 14);
    checkResult("t2_100div7", 8'h0E, 8'h02, 1'b0, 1'b0);
    applyStimulus(8'h02, 14);
    checkResult("t2_chain", 8'h07, 8'h00, 1'b0, 1'b0);

    loadB(8'h07);
    applyStimulus(8'hC5, 14);
    checkResult("t3_small", 8'h00, 8'h07, 1'b0, 1'b0);
    loadB(8'h80);
    applyStimulus(8'hFF, 14);
    checkResult("t3_ovf", 8'h80, 8'h00, 1'b0, 1'b1);

    loadB(8'h25);
    applyStimulus(8'h00, 14);
    checkResult("t4_divzero", 8'hFF, 8'h25, 1'b1, 1'b0);
    loadB(8'h25);
    applyStimulus(8'h05, 14);
    checkResult("t4_clear", 8'h07, 8'h02, 1'b0, 1'b0);

    // Reset during the fourth iteration cycle
    loadB(8'h64);
    S = 8'h07;
    Run = 1'b0;
    tick(6);
    Reset = 1'b1;
    #1;
    checkResult("t5_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1);
    Reset = 1'b0;
    Run = 1'b1;
    tick(1);
    loadB(8'h64);
    applyStimulus(8'h07, 14);
    checkResult("t5_after", 8'h0E, 8'h02, 1'b0, 1'b0);

    // Load pulse mid-run is ignored; a long-held Run never restarts
    loadB(8'hC5);
    S = 8'h07;
    Run = 1'b0;
    tick(4);
    ClearA_LoadB = 1'b0;
    S = 8'h11;
    tick(1);
    ClearA_LoadB = 1'b1;
    tick(110);
    checkResult("t6_hold", 8'hF8, 8'hFD, 1'b0, 1'b0);
    Run = 1'b1;
    tick(2);

    for (int i = 0; i < 60; i++) begin
      int hold;
      if ($urandom_range(0, 3) != 0) loadB(randOperand());
      S = randOperand();
      Run = 1'b0;
      hold = int'($urandom_range(2, 16));
      for (int c = 0; c < hold; c++) begin
        ClearA_LoadB = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
        tick(1);
      end
      ClearA_LoadB = 1'b1;
      Run = 1'b1;
      S = 8'($urandom);
      tick(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 19) == 0) begin
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
      end
    end
    tick(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
